// File: rtl/uart_defs.sv
// Shared 8N1 UART definitions: frame constants, FSM state encodings and the
// bit-period derivation used by the echo responder.
package uart_defs;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Clock cycles per serial bit; clamped so the half-bit wait is never empty.
    function automatic int clks_per_bit(input int clk_freq, input int baudrate);
        int cpb;
        cpb = clk_freq / baudrate;
        return (cpb < 4) ? 4 : cpb;
    endfunction

endpackage

// File: rtl/uart_echo_responder_if.sv
// Line and status bundle of the echo responder; the responder uses the slave
// modport, whoever drives the line and watches the flags uses the master one.
interface uart_echo_responder_if;
    import uart_defs::*;

    // rx_valid and frame_error are single-cycle strobes with no ready: the
    // consumer must sample them in the cycle they are high; rx_data holds.
    logic                 serial_in;
    logic                 echo_en;
    logic                 serial_out;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_error;
    logic                 overflow;
    logic                 tx_busy;
    rx_state_t            rx_state;
    tx_state_t            tx_state;

    modport slave (
        input  serial_in, echo_en,
        output serial_out, rx_data, rx_valid, frame_error, overflow, tx_busy,
               rx_state, tx_state
    );

    modport master (
        output serial_in, echo_en,
        input  serial_out, rx_data, rx_valid, frame_error, overflow, tx_busy,
               rx_state, tx_state
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty flags; pushes while
// full and pops while empty are ignored.
module uart_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_n;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_n = count;
        case ({do_push, do_pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            full  <= (count_n == (PTR_W+1)'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_echo_responder.sv
// Far-end UART responder: receives 8N1 frames, buffers good bytes and
// re-transmits them in arrival order when echo is enabled.
module uart_echo_responder
    import uart_defs::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUDRATE   = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_echo_responder_if.slave  bus
);

    localparam int CPB       = clks_per_bit(CLK_FREQ, BAUDRATE);
    localparam int STOP_CLKS = CPB * STOP_BITS;
    localparam int CNT_W     = $clog2(STOP_CLKS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    logic [1:0] sync_q;
    logic       line;
    logic       line_prev;

    rx_state_t            rx_state, rx_state_n;
    logic [CNT_W-1:0]     rx_cnt, rx_cnt_n;
    logic [2:0]           rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic [DATA_BITS-1:0] rx_data, rx_data_n;
    logic                 rx_valid, rx_valid_n;
    logic                 frame_error, frame_error_n;
    logic                 overflow;

    tx_state_t            tx_state, tx_state_n;
    logic [CNT_W-1:0]     tx_cnt, tx_cnt_n;
    logic [2:0]           tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 tx_line, tx_line_n;

    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= 2'b11;
            line_prev <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], bus.serial_in};
            line_prev <= sync_q[1];
        end
    end

    assign line = sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_state    <= rx_state_n;
            rx_cnt      <= rx_cnt_n;
            rx_bit      <= rx_bit_n;
            rx_shift    <= rx_shift_n;
            rx_data     <= rx_data_n;
            rx_valid    <= rx_valid_n;
            frame_error <= frame_error_n;
        end
    end

    always_comb begin
        rx_state_n    = rx_state;
        rx_cnt_n      = rx_cnt + 1'b1;
        rx_bit_n      = rx_bit;
        rx_shift_n    = rx_shift;
        rx_data_n     = rx_data;
        rx_valid_n    = 1'b0;
        frame_error_n = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (line_prev && !line) rx_state_n = RX_START;
            end
            RX_START: begin
                // A start bit that is already gone at mid-bit was a glitch.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {line, rx_shift[DATA_BITS-1:1]};
                    rx_bit_n   = rx_bit + 1'b1;
                    if (rx_bit == LAST_BIT) rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
                    if (line) begin
                        rx_data_n  = rx_shift;
                        rx_valid_n = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        frame_error_n = 1'b1;
                        rx_state_n    = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_n = '0;
                if (line) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // rx_valid doubles as the push strobe, so a byte lands one cycle after it.
    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) overflow <= 1'b0;
        else if (rx_valid && fifo_full) overflow <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_line  <= tx_line_n;
        end
    end

    // tx_line is registered alongside tx_state so the line and tx_busy align.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = tx_line;
        fifo_pop   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n  = '0;
                tx_line_n = 1'b1;
                if (!fifo_empty && bus.echo_en) begin
                    fifo_pop   = 1'b1;
                    tx_shift_n = fifo_data;
                    tx_line_n  = 1'b0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_line_n  = tx_shift[0];
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    tx_bit_n = tx_bit + 1'b1;
                    if (tx_bit == LAST_BIT) begin
                        tx_line_n  = 1'b1;
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_shift_n = {1'b0, tx_shift[DATA_BITS-1:1]};
                        tx_line_n  = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == STOP_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    assign bus.serial_out  = tx_line;
    assign bus.rx_data     = rx_data;
    assign bus.rx_valid    = rx_valid;
    assign bus.frame_error = frame_error;
    assign bus.overflow    = overflow;
    assign bus.tx_busy     = (tx_state != TX_IDLE);
    assign bus.rx_state    = rx_state;
    assign bus.tx_state    = tx_state;

endmodule
